bit_flip_checker: RTL and testbench

Downstream consumer of the single-bit fault injector. Accepts a golden 32-bit word and the word returned by the injector, XORs them, and scans the difference one bit per clock. Reports the number of flipped bits, the lowest flipped index, and whether exactly one flip occurred. Results are delivered through a valid/ready handshake so the fault-injection bench can confirm that each injection hit exactly the requested bit.

---
 rtl/bit_flip_pkg.sv | 16 +
 rtl/bit_flip_checker.sv | 88 ++++++++
 tb/tb_bit_flip_checker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_flip_pkg.sv
// Shared types for the fault-injection bench: checker FSM states
// and the bit-index type also used by the injector's index port.
package bit_flip_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int IDXW_DEF  = $clog2(WIDTH_DEF);

    typedef logic [IDXW_DEF-1:0] bit_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/bit_flip_checker.sv
// Serial bit-flip checker: XORs golden and test words, then scans
// the difference one bit per clock to count and locate flips.
module bit_flip_checker
    import bit_flip_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW:0]   flip_count,
    output logic [IDXW-1:0] first_index,
    output logic            single_flip,
    output logic            no_flip
);

    localparam logic [IDXW-1:0] LAST_POS = IDXW'(WIDTH - 1);

    chk_state_t       r_state;
    logic [WIDTH-1:0] r_diff;
    logic [IDXW-1:0]  r_pos;
    logic [IDXW-1:0]  r_first;
    logic [IDXW:0]    r_count;
    logic             r_found;
    logic             w_bit;

    assign w_bit = r_diff[r_pos];

    // Fixed-length scan: no early exit, so latency never depends on data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_diff  <= '0;
            r_pos   <= '0;
            r_first <= '0;
            r_count <= '0;
            r_found <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_diff  <= golden ^ in;
                        r_pos   <= '0;
                        r_first <= '0;
                        r_count <= '0;
                        r_found <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_bit) begin
                        r_count <= r_count + 1'b1;
                        if (!r_found) begin
                            r_first <= r_pos;
                            r_found <= 1'b1;
                        end
                    end
                    r_pos <= r_pos + 1'b1;
                    if (r_pos == LAST_POS) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign flip_count  = r_count;
    assign first_index = r_first;
    assign single_flip = (r_count == (IDXW+1)'(1));
    assign no_flip     = (r_count == '0);

endmodule

// File: tb/tb_bit_flip_checker.sv
// Self-checking bench for bit_flip_checker: directed table,
// back-pressure and reset corners, then random pairs vs a model.
module tb_bit_flip_checker;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] golden;
    logic [31:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  flip_count;
    logic [4:0]  first_index;
    logic        single_flip;
    logic        no_flip;

    int n_cmp = 0;
    int n_bad = 0;
    int k;

    typedef struct {
        string       name;
        logic [31:0] g;
        logic [31:0] t;
        int          exp_count;
        int          exp_first;
    } vec_t;

    vec_t vecs[4];

    bit_flip_checker dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .golden(golden),
        .in(in_w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flip_count(flip_count),
        .first_index(first_index),
        .single_flip(single_flip),
        .no_flip(no_flip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_count(input logic [31:0] d);
        return $countones(d);
    endfunction

    function automatic int ref_first(input logic [31:0] d);
        for (int i = 0; i < W; i++) begin
            if (d[i]) return i;
        end
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] g, input logic [31:0] t);
        int n;
        golden   = g;
        in_w     = t;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        k        = 1;
        in_valid = 1'b0;
        golden   = $urandom;
        in_w     = $urandom;
    endtask

    task automatic wait_check(input string nm, input logic [31:0] g,
                              input logic [31:0] t, input bit do_lat);
        logic [31:0] d;
        d = g ^ t;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (do_lat) chk({nm, "_latency"}, k, W + 1);
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_count"}, int'(flip_count), ref_count(d));
        chk({nm, "_first"}, int'(first_index), ref_first(d));
        chk({nm, "_single"}, int'(single_flip), int'(ref_count(d) == 1));
        chk({nm, "_noflip"}, int'(no_flip), int'(ref_count(d) == 0));
    endtask

    initial begin
        logic [31:0] g, t, d;
        logic [5:0]  h_cnt;
        logic [4:0]  h_first;
        int          mode;

        vecs[0] = '{"single16", 32'h0000_0000, 32'h0001_0000, 1, 16};
        vecs[1] = '{"noflip",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0};
        vecs[2] = '{"extremes", 32'h0000_0000, 32'h8000_0001, 2, 0};
        vecs[3] = '{"allbits",  32'hFFFF_FFFF, 32'h0000_0000, 32, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        golden    = '0;
        in_w      = '0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(flip_count), 0);
        chk("rst_first", int'(first_index), 0);
        chk("rst_single", int'(single_flip), 0);
        chk("rst_noflip", int'(no_flip), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].g, vecs[i].t);
            wait_check(vecs[i].name, vecs[i].g, vecs[i].t, 1'b1);
            chk({vecs[i].name, "_tbl_count"}, int'(flip_count),
                vecs[i].exp_count);
            chk({vecs[i].name, "_tbl_first"}, int'(first_index),
                vecs[i].exp_first);
            @(negedge clk);
        end

        // Back-pressure: DONE held while a new pair waits upstream.
        out_ready = 1'b0;
        send(32'h0000_0000, 32'h0000_0030);
        wait_check("bp_a", 32'h0000_0000, 32'h0000_0030, 1'b1);
        h_cnt    = flip_count;
        h_first  = first_index;
        golden   = 32'h1234_5678;
        in_w     = 32'h1234_5678 ^ 32'h0400_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_ready", int'(in_ready), 0);
            chk("bp_hold_count", int'(flip_count), int'(h_cnt));
            chk("bp_hold_first", int'(first_index), int'(h_first));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_ready", int'(in_ready), 1);
        chk("bp_idle_valid", int'(out_valid), 0);
        send(32'h1234_5678, 32'h1234_5678 ^ 32'h0400_0000);
        chk("bp_b_accepted", int'(in_ready), 0);
        wait_check("bp_b", 32'h1234_5678, 32'h1234_5678 ^ 32'h0400_0000,
                   1'b1);
        @(negedge clk);

        // Reset between edges during scan cycle 10.
        send(32'h0000_0000, 32'h0000_FFFF);
        while (k < 10) begin
            @(negedge clk);
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", int'(in_ready), 1);
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_count", int'(flip_count), 0);
        chk("mrst_first", int'(first_index), 0);
        chk("mrst_single", int'(single_flip), 0);
        chk("mrst_noflip", int'(no_flip), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h0000_0000, 32'h0000_0100);
        wait_check("post_rst", 32'h0000_0000, 32'h0000_0100, 1'b1);
        chk("post_rst_first8", int'(first_index), 8);
        chk("post_rst_count1", int'(flip_count), 1);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            g = $urandom;
            case (mode)
                0: d = $urandom;
                1: d = 32'h1 << $urandom_range(0, W - 1);
                2: d = '0;
                default: d = $urandom & $urandom & $urandom;
            endcase
            t = g ^ d;
            send(g, t);
            wait_check("rand", g, t, 1'b1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
